// File: rtl/uart_rom_loader.sv
// Boot loader: receives an A5-synced image over 8N1 UART, writes 32-bit words to the
// instruction ROM and holds the CPU in reset until the XOR checksum verifies.
module uart_rom_loader #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          ROM_DEPTH    = 256,
  parameter logic [31:0] BASE_ADDR    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en_i,
  input  logic        uart_rx_i,
  output logic        w_en_o,
  output logic [31:0] w_addr_o,
  output logic [31:0] w_data_o,
  output logic [3:0]  w_sel_o,
  output logic        cpu_hold_o,
  output logic        done_o,
  output logic        err_o
);

  // state    | meaning
  // L_IDLE   | waiting for sync byte A5 (or bypass when load_en_i = 0)
  // L_LEN0   | expecting word count low byte
  // L_LEN1   | expecting word count high byte, range check
  // L_DATA   | packing bytes into words, one ROM write per word
  // L_CSUM   | expecting XOR checksum byte
  // L_DONE   | image verified, core released; terminal until rst
  // L_ERR    | framing/length/checksum error; a new A5 restarts at L_LEN0

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_BIT = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {L_IDLE, L_LEN0, L_LEN1, L_DATA, L_CSUM, L_DONE, L_ERR} ld_state_t;

  logic            rx_s1_q, rx_s2_q, rx_prev_q;
  rx_state_t       rx_state_q, rx_state_d;
  logic [CW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            rx_valid, frame_err;

  ld_state_t       ld_q, ld_d;
  logic [15:0]     n_q, n_d, k_q, k_d;
  logic [1:0]      bidx_q, bidx_d;
  logic [23:0]     word_q, word_d;
  logic [7:0]      csum_q, csum_d;
  logic            w_en_q, w_en_d;
  logic [3:0]      w_sel_q, w_sel_d;
  logic [31:0]     w_addr_q, w_addr_d, w_data_q, w_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ld_q       <= L_IDLE;
      n_q        <= '0;
      k_q        <= '0;
      bidx_q     <= '0;
      word_q     <= '0;
      csum_q     <= '0;
      w_en_q     <= 1'b0;
      w_sel_q    <= 4'h0;
      w_addr_q   <= BASE_ADDR;
      w_data_q   <= '0;
    end else begin
      rx_s1_q    <= uart_rx_i;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_state_q <= rx_state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ld_q       <= ld_d;
      n_q        <= n_d;
      k_q        <= k_d;
      bidx_q     <= bidx_d;
      word_q     <= word_d;
      csum_q     <= csum_d;
      w_en_q     <= w_en_d;
      w_sel_q    <= w_sel_d;
      w_addr_q   <= w_addr_d;
      w_data_q   <= w_data_d;
    end
  end

  // Baud timer is a down-counter; every sample point is its terminal count.
  always_comb begin
    rx_state_d = rx_state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rx_valid   = 1'b0;
    frame_err  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_state_d = RX_START;
          baud_d     = HALF_BIT;
        end
      end
      RX_START: begin
        if (baud_q == '0) begin
          if (!rx_s2_q) begin
            rx_state_d = RX_DATA;
            baud_d     = FULL_BIT;
            bit_d      = 3'd0;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      RX_DATA: begin
        if (baud_q == '0) begin
          shift_d = {rx_s2_q, shift_q[7:1]};
          baud_d  = FULL_BIT;
          if (bit_q == 3'd7) rx_state_d = RX_STOP;
          else               bit_d      = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      RX_STOP: begin
        if (baud_q == '0) begin
          rx_valid   = rx_s2_q;
          frame_err  = !rx_s2_q;
          rx_state_d = RX_IDLE;
        end else begin
          baud_d = baud_q - CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    ld_d     = ld_q;
    n_d      = n_q;
    k_d      = k_q;
    bidx_d   = bidx_q;
    word_d   = word_q;
    csum_d   = csum_q;
    w_en_d   = 1'b0;
    w_sel_d  = 4'h0;
    w_addr_d = w_addr_q;
    w_data_d = w_data_q;
    case (ld_q)
      L_IDLE: begin
        if (!load_en_i) begin
          ld_d = L_DONE;
        end else if (rx_valid && shift_q == 8'hA5) begin
          ld_d   = L_LEN0;
          csum_d = 8'h00;
        end
      end
      L_LEN0: begin
        if (rx_valid) begin
          n_d    = {8'h00, shift_q};
          csum_d = csum_q ^ shift_q;
          ld_d   = L_LEN1;
        end
      end
      L_LEN1: begin
        if (rx_valid) begin
          n_d    = {shift_q, n_q[7:0]};
          csum_d = csum_q ^ shift_q;
          k_d    = 16'd0;
          bidx_d = 2'd0;
          if (n_d > 16'(ROM_DEPTH)) ld_d = L_ERR;
          else if (n_d == 16'd0)    ld_d = L_CSUM;
          else                      ld_d = L_DATA;
        end
      end
      L_DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ shift_q;
          bidx_d = bidx_q + 2'd1;
          case (bidx_q)
            2'd0: word_d[7:0]   = shift_q;
            2'd1: word_d[15:8]  = shift_q;
            2'd2: word_d[23:16] = shift_q;
            default: begin
              w_en_d   = 1'b1;
              w_sel_d  = 4'hF;
              w_data_d = {shift_q, word_q};
              w_addr_d = BASE_ADDR + {14'b0, k_q, 2'b00};
              k_d      = k_q + 16'd1;
              if (k_q + 16'd1 == n_q) ld_d = L_CSUM;
            end
          endcase
        end
      end
      L_CSUM: begin
        if (rx_valid) ld_d = (shift_q == csum_q) ? L_DONE : L_ERR;
      end
      L_ERR: begin
        if (rx_valid && shift_q == 8'hA5) begin
          ld_d   = L_LEN0;
          csum_d = 8'h00;
        end
      end
      L_DONE:  ld_d = L_DONE;
      default: ld_d = L_IDLE;
    endcase
    if (frame_err && (ld_q inside {L_LEN0, L_LEN1, L_DATA, L_CSUM})) ld_d = L_ERR;
  end

  assign w_en_o     = w_en_q;
  assign w_sel_o    = w_sel_q;
  assign w_addr_o   = w_addr_q;
  assign w_data_o   = w_data_q;
  assign cpu_hold_o = (ld_q != L_DONE);
  assign done_o     = (ld_q == L_DONE);
  assign err_o      = (ld_q == L_ERR);

endmodule
